// File: rtl/sa_global_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sa_global_if : request / grant / credit bundle for one output port's       |
// | global switch allocator.                                 Revision: 1.0     |
// +----------------------------------------------------------------------------+
interface sa_global_if #(
  parameter int INPUT_PORT_NUM = 5,
  parameter int VC_NUM         = 4,
  parameter int VC_DEPTH       = 2,
  parameter int QOS_W          = 4
);
  localparam int IDX_W  = (INPUT_PORT_NUM > 1) ? $clog2(INPUT_PORT_NUM) : 1;
  localparam int VCID_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int CRD_W  = $clog2(VC_DEPTH + 1);

  logic [INPUT_PORT_NUM-1:0]        sa_local_vld_i;
  logic [INPUT_PORT_NUM*QOS_W-1:0]  sa_local_qos_value_i;
  logic [INPUT_PORT_NUM*VCID_W-1:0] sa_local_out_vc_i;
  logic                             credit_ret_vld_i;
  logic [VCID_W-1:0]                credit_ret_vc_i;
  logic [INPUT_PORT_NUM-1:0]        inport_read_enable_o;
  logic [IDX_W-1:0]                 grt_idx_o;
  logic                             st_vld_o;
  logic [INPUT_PORT_NUM-1:0]        st_inport_oh_o;
  logic [VCID_W-1:0]                st_out_vc_o;
  logic [VC_NUM*CRD_W-1:0]          credit_cnt_o;
  logic                             credit_err_o;

  // Master side: local SA stages plus the downstream credit return path.
  modport master (
    output sa_local_vld_i, sa_local_qos_value_i, sa_local_out_vc_i,
    output credit_ret_vld_i, credit_ret_vc_i,
    input  inport_read_enable_o, grt_idx_o,
    input  st_vld_o, st_inport_oh_o, st_out_vc_o,
    input  credit_cnt_o, credit_err_o
  );

  modport slave (
    input  sa_local_vld_i, sa_local_qos_value_i, sa_local_out_vc_i,
    input  credit_ret_vld_i, credit_ret_vc_i,
    output inport_read_enable_o, grt_idx_o,
    output st_vld_o, st_inport_oh_o, st_out_vc_o,
    output credit_cnt_o, credit_err_o
  );
endinterface
`default_nettype wire

// File: rtl/sa_global.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sa_global : QoS-filtered round-robin switch allocator for one output port  |
// | with per-VC downstream credit tracking and a registered ST stage. Rev 1.0  |
// +----------------------------------------------------------------------------+
module sa_global #(
  parameter int INPUT_PORT_NUM = 5,
  parameter int VC_NUM         = 4,
  parameter int VC_DEPTH       = 2,
  parameter int QOS_W          = 4
) (
  input  logic       clk,
  input  logic       rstn,
  sa_global_if.slave sa_bus
);
  localparam int IDX_W  = (INPUT_PORT_NUM > 1) ? $clog2(INPUT_PORT_NUM) : 1;
  localparam int VCID_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int CRD_W  = $clog2(VC_DEPTH + 1);

  localparam logic [CRD_W-1:0] C_DEPTH    = CRD_W'(VC_DEPTH);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(INPUT_PORT_NUM - 1);

  logic [CRD_W-1:0]          r_credit [VC_NUM];
  logic [IDX_W-1:0]          r_rr_ptr;
  logic                      r_st_vld;
  logic [INPUT_PORT_NUM-1:0] r_st_oh;
  logic [VCID_W-1:0]         r_st_vc;
  logic                      r_err;

  logic [VCID_W-1:0]         w_vc  [INPUT_PORT_NUM];
  logic [QOS_W-1:0]          w_qos [INPUT_PORT_NUM];
  logic [INPUT_PORT_NUM-1:0] w_elig;
  logic [INPUT_PORT_NUM-1:0] w_keep;
  logic [QOS_W-1:0]          w_max_qos;
  logic [INPUT_PORT_NUM-1:0] w_grant;
  logic [IDX_W-1:0]          w_grt_idx;
  logic [VCID_W-1:0]         w_win_vc;
  logic                      w_found;
  int                        w_scan;
  logic [VC_NUM-1:0]         w_dec;
  logic [VC_NUM-1:0]         w_inc;
  logic [VC_NUM-1:0]         w_full;
  logic                      w_ret_bad;
  logic                      w_ovf;

  // Eligibility needs a live credit on the target VC; the QoS filter then
  // keeps only eligible ports at the highest eligible QoS level.
  always_comb begin
    w_elig    = '0;
    w_keep    = '0;
    w_max_qos = '0;
    for (int i = 0; i < INPUT_PORT_NUM; i++) begin
      w_vc[i]  = sa_bus.sa_local_out_vc_i[i*VCID_W +: VCID_W];
      w_qos[i] = sa_bus.sa_local_qos_value_i[i*QOS_W +: QOS_W];
      w_elig[i] = sa_bus.sa_local_vld_i[i]
                  && (32'(w_vc[i]) < VC_NUM)
                  && (r_credit[w_vc[i]] != '0);
      if (w_elig[i] && (w_qos[i] > w_max_qos)) begin
        w_max_qos = w_qos[i];
      end
    end
    for (int i = 0; i < INPUT_PORT_NUM; i++) begin
      w_keep[i] = w_elig[i] && (w_qos[i] == w_max_qos);
    end
  end

  // Round-robin scan over the survivors, starting at the pointer and wrapping.
  always_comb begin
    w_grant   = '0;
    w_grt_idx = '0;
    w_win_vc  = '0;
    w_found   = 1'b0;
    w_scan    = 0;
    for (int off = 0; off < INPUT_PORT_NUM; off++) begin
      w_scan = int'(r_rr_ptr) + off;
      if (w_scan >= INPUT_PORT_NUM) begin
        w_scan = w_scan - INPUT_PORT_NUM;
      end
      if (!w_found && w_keep[w_scan]) begin
        w_found          = 1'b1;
        w_grant[w_scan]  = 1'b1;
        w_grt_idx        = IDX_W'(w_scan);
        w_win_vc         = w_vc[w_scan];
      end
    end
  end

  // Out-of-range return VCs are dropped and flagged rather than aliased.
  always_comb begin
    w_ret_bad = sa_bus.credit_ret_vld_i && (32'(sa_bus.credit_ret_vc_i) >= VC_NUM);
    w_dec     = '0;
    w_inc     = '0;
    w_full    = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      w_dec[v]  = w_found && (w_win_vc == VCID_W'(v));
      w_inc[v]  = sa_bus.credit_ret_vld_i && !w_ret_bad
                  && (sa_bus.credit_ret_vc_i == VCID_W'(v));
      w_full[v] = (r_credit[v] == C_DEPTH);
    end
    w_ovf = |(w_inc & ~w_dec & w_full);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int v = 0; v < VC_NUM; v++) begin
        r_credit[v] <= C_DEPTH;
      end
      r_rr_ptr <= '0;
      r_st_vld <= 1'b0;
      r_st_oh  <= '0;
      r_st_vc  <= '0;
      r_err    <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_dec[v] && !w_inc[v]) begin
          r_credit[v] <= r_credit[v] - CRD_W'(1);
        end else if (w_inc[v] && !w_dec[v] && !w_full[v]) begin
          r_credit[v] <= r_credit[v] + CRD_W'(1);
        end
      end
      if (w_ret_bad || w_ovf) begin
        r_err <= 1'b1;
      end
      if (w_found) begin
        r_rr_ptr <= (w_grt_idx == C_LAST_IDX) ? '0 : w_grt_idx + IDX_W'(1);
      end
      r_st_vld <= w_found;
      r_st_oh  <= w_grant;
      r_st_vc  <= w_found ? w_win_vc : '0;
    end
  end

  for (genvar v = 0; v < VC_NUM; v++) begin : g_credit_out
    assign sa_bus.credit_cnt_o[v*CRD_W +: CRD_W] = r_credit[v];
  end

  assign sa_bus.inport_read_enable_o = w_grant;
  assign sa_bus.grt_idx_o            = w_grt_idx;
  assign sa_bus.st_vld_o             = r_st_vld;
  assign sa_bus.st_inport_oh_o       = r_st_oh;
  assign sa_bus.st_out_vc_o          = r_st_vc;
  assign sa_bus.credit_err_o         = r_err;
endmodule
`default_nettype wire

// File: tb/tb_sa_global.sv
`default_nettype none
// Bench for sa_global: directed corner cases plus random traffic, all checked
// against a behavioural allocator/credit model.
module tb_sa_global;
  localparam int N = 5;
  localparam int V = 4;
  localparam int D = 2;
  localparam int Q = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sa_global_if #(.INPUT_PORT_NUM(N), .VC_NUM(V), .VC_DEPTH(D), .QOS_W(Q)) bus ();
  sa_global #(.INPUT_PORT_NUM(N), .VC_NUM(V), .VC_DEPTH(D), .QOS_W(Q)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .sa_bus (bus)
  );

  // Stimulus
  bit vld [N];
  int qos [N];
  int vcs [N];
  bit ret_vld;
  int ret_vc;

  // Reference model state
  int m_cr [V];
  int m_ptr;
  bit m_err;
  bit m_st_vld;
  int m_st_port;
  int m_st_vc;
  int m_gnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0; qos[i] = 0; vcs[i] = 0;
    end
    ret_vld = 1'b0;
    ret_vc  = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.sa_local_vld_i[i]               = vld[i];
      bus.sa_local_qos_value_i[i*Q +: Q]  = Q'(qos[i]);
      bus.sa_local_out_vc_i[i*2 +: 2]     = 2'(vcs[i]);
    end
    bus.credit_ret_vld_i = ret_vld;
    bus.credit_ret_vc_i  = 2'(ret_vc);
  endtask

  // Highest eligible QoS wins; among ties, the port closest after the pointer.
  function automatic void model_arb();
    int maxq;
    int bestd;
    int d;
    maxq  = -1;
    bestd = N;
    m_gnt = -1;
    for (int i = 0; i < N; i++)
      if (vld[i] && m_cr[vcs[i]] > 0 && qos[i] > maxq) maxq = qos[i];
    for (int i = 0; i < N; i++) begin
      if (vld[i] && m_cr[vcs[i]] > 0 && qos[i] == maxq) begin
        d = (i - m_ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          m_gnt = i;
        end
      end
    end
  endfunction

  function automatic void model_update();
    bit dec;
    bit inc;
    for (int v = 0; v < V; v++) begin
      dec = (m_gnt >= 0) && (vcs[m_gnt] == v);
      inc = ret_vld && (ret_vc == v);
      if (dec && !inc) m_cr[v]--;
      else if (inc && !dec) begin
        if (m_cr[v] < D) m_cr[v]++;
        else m_err = 1'b1;
      end
    end
    if (m_gnt >= 0) m_ptr = (m_gnt + 1) % N;
    m_st_vld  = (m_gnt >= 0);
    m_st_port = m_gnt;
    m_st_vc   = (m_gnt >= 0) ? vcs[m_gnt] : 0;
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < V; v++) m_cr[v] = D;
    m_ptr = 0; m_err = 1'b0; m_st_vld = 1'b0; m_st_port = -1; m_st_vc = 0;
  endfunction

  function automatic logic [31:0] exp_credit();
    logic [31:0] e;
    e = '0;
    for (int v = 0; v < V; v++) e[v*2 +: 2] = 2'(m_cr[v]);
    return e;
  endfunction

  task automatic check_regs();
    chk("st_vld", 32'(bus.st_vld_o), 32'(m_st_vld));
    chk("st_oh", 32'(bus.st_inport_oh_o), m_st_vld ? (32'd1 << m_st_port) : 32'd0);
    chk("st_vc", 32'(bus.st_out_vc_o), 32'(m_st_vc));
    chk("credit_cnt", 32'(bus.credit_cnt_o), exp_credit());
    chk("credit_err", 32'(bus.credit_err_o), 32'(m_err));
  endtask

  // One clock: comb grant checked at the falling edge, registers just after the rise.
  task automatic cycle(input int exp_idx = -2);
    drive();
    model_arb();
    @(negedge clk);
    chk("read_en", 32'(bus.inport_read_enable_o), (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
    chk("grt_idx", 32'(bus.grt_idx_o), (m_gnt >= 0) ? 32'(m_gnt) : 32'd0);
    if (exp_idx >= 0) chk("grt_fixed", 32'(bus.grt_idx_o), 32'(exp_idx));
    if (exp_idx == -1) chk("no_grant", 32'(bus.inport_read_enable_o), 32'd0);
    @(posedge clk);
    model_update();
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    drive();
    rstn = 1'b0;
    #1;
    model_reset();
    check_regs();
    model_arb();
    chk("rst_read_en", 32'(bus.inport_read_enable_o), (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  int order [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    clear_inputs();
    drive();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_credit", 32'(bus.credit_cnt_o), 32'h0000_00AA);

    // Single request, then the registered ST view and the consumed credit
    vld[2] = 1'b1; qos[2] = 3; vcs[2] = 1;
    cycle(2);
    chk("t1_st_vc", 32'(bus.st_out_vc_o), 32'd1);
    chk("t1_credit", 32'(bus.credit_cnt_o), 32'h0000_00A6);
    clear_inputs();
    cycle(-1);

    // Round robin with equal QoS and steady returns, then wrap from pointer 4
    do_reset();
    for (int i = 0; i < N; i++) begin vcs[i] = 0; qos[i] = 5; end
    vld[0] = 1'b1; vld[1] = 1'b1; vld[3] = 1'b1;
    ret_vld = 1'b1; ret_vc = 0;
    for (int k = 0; k < 6; k++) cycle(order[k]);
    vld[1] = 1'b0; vld[3] = 1'b0; vld[4] = 1'b1;
    cycle(4);
    cycle(0);

    // QoS dominance, then fallback when the high-QoS VC runs dry
    do_reset();
    clear_inputs();
    vld[1] = 1'b1; qos[1] = 2; vcs[1] = 0;
    vld[4] = 1'b1; qos[4] = 7; vcs[4] = 1;
    cycle(4);
    cycle(4);
    cycle(1);

    // Drain VC0, block, return a credit, resume one cycle later
    do_reset();
    clear_inputs();
    vld[0] = 1'b1; qos[0] = 1; vcs[0] = 0;
    cycle(0);
    cycle(0);
    cycle(-1);
    chk("t4_st_idle", 32'(bus.st_vld_o), 32'd0);
    ret_vld = 1'b1; ret_vc = 0;
    cycle(-1);
    ret_vld = 1'b0;
    cycle(0);

    // Simultaneous grant and return on VC2, then overflow on full VC3
    do_reset();
    clear_inputs();
    vld[3] = 1'b1; qos[3] = 4; vcs[3] = 2;
    ret_vld = 1'b1; ret_vc = 2;
    cycle(3);
    chk("t5_vc2_same", 32'(bus.credit_cnt_o[5:4]), 32'd2);
    clear_inputs();
    ret_vld = 1'b1; ret_vc = 3;
    cycle(-1);
    ret_vld = 1'b0;
    cycle(-1);
    cycle(-1);
    chk("t5_err_sticky", 32'(bus.credit_err_o), 32'd1);

    // Reset in the middle of a transfer stream
    clear_inputs();
    for (int i = 0; i < N; i++) begin vld[i] = 1'b1; qos[i] = 2; vcs[i] = i % V; end
    cycle();
    cycle();
    do_reset();
    cycle(0);

    // Random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        vld[i] = ($urandom_range(0, 2) != 0);
        qos[i] = $urandom_range(0, 3);
        vcs[i] = $urandom_range(0, V - 1);
      end
      ret_vld = ($urandom_range(0, 2) == 0);
      ret_vc  = $urandom_range(0, V - 1);
      if (n % 130 == 129) do_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
